// File: rtl/prbs9_checker.sv
// rtl/prbs9_checker.sv - PRBS9 (x^9+x^5+1) lock/error checker with windowed loss-of-lock
// Define PRBS9_CHK_BER_EN to build the bit/error statistics counters.
module prbs9_checker #(
    parameter int LOCK_CNT = 18,
    parameter int WIN      = 64,
    parameter int ERR_THR  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic        i_bit,
    input  logic        i_clr,
    output logic        o_lock,
    output logic        o_err,
    output logic [31:0] o_bit_cnt,
    output logic [31:0] o_err_cnt
);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t      state_q;
    logic [8:0]  h_q;
    logic [3:0]  fill_q;
    logic [7:0]  match_q;
    logic [15:0] win_q;
    logic [15:0] werr_q;
    logic        lock_q;
    logic        err_q;

    logic        pred;
    logic        mis;
    logic [15:0] werr_inc;

    assign pred     = h_q[0] ^ h_q[4];
    assign mis      = i_bit ^ pred;
    assign werr_inc = werr_q + {15'd0, mis};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEARCH;
            h_q     <= '0;
            fill_q  <= '0;
            match_q <= '0;
            win_q   <= '0;
            werr_q  <= '0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (i_enable) begin
                case (state_q)
                    SEARCH: begin
                        h_q <= {i_bit, h_q[8:1]};
                        if (fill_q != 4'd9) begin
                            fill_q <= fill_q + 4'd1;
                        end else if (!mis) begin
                            if (match_q == 8'(LOCK_CNT - 1)) begin
                                state_q <= LOCKED;
                                lock_q  <= 1'b1;
                                match_q <= '0;
                                win_q   <= '0;
                                werr_q  <= '0;
                            end else begin
                                match_q <= match_q + 8'd1;
                            end
                        end else begin
                            match_q <= '0;
                        end
                    end
                    LOCKED: begin
                        // Self-running history: received errors never feed back into predictions.
                        h_q   <= {pred, h_q[8:1]};
                        err_q <= mis;
                        if (werr_inc >= 16'(ERR_THR)) begin
                            state_q <= SEARCH;
                            lock_q  <= 1'b0;
                            fill_q  <= '0;
                            match_q <= '0;
                        end else if (win_q == 16'(WIN - 1)) begin
                            win_q  <= '0;
                            werr_q <= '0;
                        end else begin
                            win_q  <= win_q + 16'd1;
                            werr_q <= werr_inc;
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
        end
    end

    assign o_lock = lock_q;
    assign o_err  = err_q;

`ifdef PRBS9_CHK_BER_EN
    logic [31:0] bit_cnt_q, bit_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;
        if (i_clr) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end else if (i_enable && state_q == LOCKED) begin
            if (bit_cnt_q != 32'hFFFF_FFFF) bit_cnt_d = bit_cnt_q + 32'd1;
            if (mis && err_cnt_q != 32'hFFFF_FFFF) err_cnt_d = err_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_bit_cnt = bit_cnt_q;
    assign o_err_cnt = err_cnt_q;
`else
    logic unused_clr;
    assign unused_clr = i_clr;
    assign o_bit_cnt  = '0;
    assign o_err_cnt  = '0;
`endif

endmodule

// File: tb/tb_prbs9_checker.sv
// tb/tb_prbs9_checker.sv - randomized and directed bench for prbs9_checker against a queue-based model
module tb_prbs9_checker;

    localparam int LOCK_CNT = 18;
    localparam int WIN      = 64;
    localparam int ERR_THR  = 8;
`ifdef PRBS9_CHK_BER_EN
    localparam bit BER = 1'b1;
`else
    localparam bit BER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_bit = 1'b0;
    logic        i_clr = 1'b0;
    logic        o_lock;
    logic        o_err;
    logic [31:0] o_bit_cnt;
    logic [31:0] o_err_cnt;

    always #5 clk = ~clk;

    prbs9_checker #(.LOCK_CNT(LOCK_CNT), .WIN(WIN), .ERR_THR(ERR_THR)) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_bit(i_bit), .i_clr(i_clr),
        .o_lock(o_lock), .o_err(o_err), .o_bit_cnt(o_bit_cnt), .o_err_cnt(o_err_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference PRBS9 stream seeded all-ones; prbs[k-1] is stream bit k.
    bit prbs [0:4095];

    // Behavioural model: history as a queue of the last 9 sequence bits, oldest first.
    int     m_hist[$];
    bit     m_locked;
    int     m_fill, m_match, m_win, m_werr;
    bit     m_err;
    longint m_bitc, m_errc;
    localparam longint SAT = 64'hFFFF_FFFF;

    function automatic void model_reset();
        m_hist = {};
        repeat (9) m_hist.push_back(0);
        m_locked = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
        m_err = 0; m_bitc = 0; m_errc = 0;
    endfunction

    function automatic void model_step(input bit en, input bit b, input bit clr);
        int pred;
        bit mis;
        m_err = 0;
        if (clr) begin m_bitc = 0; m_errc = 0; end
        if (!en) return;
        pred = m_hist[0] ^ m_hist[4];
        mis  = (b != pred);
        void'(m_hist.pop_front());
        if (!m_locked) begin
            m_hist.push_back(int'(b));
            if (m_fill < 9) m_fill++;
            else if (!mis) begin
                m_match++;
                if (m_match == LOCK_CNT) begin
                    m_locked = 1; m_match = 0; m_win = 0; m_werr = 0;
                end
            end else m_match = 0;
        end else begin
            m_hist.push_back(pred);
            m_err = mis;
            if (!clr) begin
                if (m_bitc < SAT) m_bitc++;
                if (mis && m_errc < SAT) m_errc++;
            end
            m_werr += int'(mis);
            if (m_werr >= ERR_THR) begin
                m_locked = 0; m_fill = 0; m_match = 0;
            end else if (m_win == WIN - 1) begin
                m_win = 0; m_werr = 0;
            end else m_win++;
        end
    endfunction

    int nbits;
    bit prev_lock;
    int lock_at[$];
    int drop_at[$];
    int err_pulses;

    task automatic step(input bit en, input bit b, input bit clr, input bit r);
        i_enable = en; i_bit = b; i_clr = clr; rst = r;
        @(posedge clk);
        if (r) model_reset(); else model_step(en, b, clr);
        #1;
        check("lock", o_lock, m_locked);
        check("err", o_err, m_err);
        check("bit_cnt", o_bit_cnt, BER ? m_bitc[31:0] : 32'd0);
        check("err_cnt", o_err_cnt, BER ? m_errc[31:0] : 32'd0);
        if (r) begin
            nbits = 0; lock_at.delete(); drop_at.delete(); err_pulses = 0;
        end else if (en) nbits++;
        if (o_lock && !prev_lock) lock_at.push_back(nbits);
        if (!o_lock && prev_lock && !r) drop_at.push_back(nbits);
        if (o_err) err_pulses++;
        prev_lock = o_lock;
    endtask

    task automatic run_stream(input int n, input int inv_lo, input int inv_hi, input bit toggle);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= n; k++) begin
            step(1'b1, prbs[k-1] ^ (k >= inv_lo && k <= inv_hi), 1'b0, 1'b0);
            if (toggle) step(1'b0, 1'($urandom), 1'b0, 1'b0);
        end
    endtask

    function automatic int first_of(input int q[$], input int idx);
        return (q.size() > idx) ? q[idx] : -1;
    endfunction

    initial begin
        int idx, burst;
        bit en, b, clr, r;
        for (int i = 0; i < 4096; i++) prbs[i] = (i < 9) ? 1'b1 : (prbs[i-9] ^ prbs[i-5]);
        model_reset();
        nbits = 0; prev_lock = 0; err_pulses = 0;

        // Reset values
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_lock", o_lock, 0);
        check("rst_bitcnt", o_bit_cnt, 0);

        // Clean stream
        run_stream(1000, 0, -1, 1'b0);
        check("clean_lock_at", first_of(lock_at, 0), 27);
        check("clean_errs", err_pulses, 0);
        check("clean_bitcnt", o_bit_cnt, BER ? 32'd973 : 32'd0);
        check("clean_errcnt", o_err_cnt, 0);

        // Single inverted bit while locked
        run_stream(1000, 100, 100, 1'b0);
        check("one_err_pulses", err_pulses, 1);
        check("one_err_drops", drop_at.size(), 0);
        check("one_err_lock", o_lock, 1);
        check("one_err_errcnt", o_err_cnt, BER ? 32'd1 : 32'd0);

        // Error burst forces loss of lock and relock
        run_stream(1000, 200, 207, 1'b0);
        check("burst_drop_at", first_of(drop_at, 0), 207);
        check("burst_relock_at", first_of(lock_at, 1), 234);
        check("burst_pulses", err_pulses, 8);
        check("burst_bitcnt", o_bit_cnt, BER ? 32'd946 : 32'd0);
        check("burst_errcnt", o_err_cnt, BER ? 32'd8 : 32'd0);

        // Enable toggling
        run_stream(1000, 0, -1, 1'b1);
        check("tog_lock_at", first_of(lock_at, 0), 27);
        check("tog_errs", err_pulses, 0);
        check("tog_bitcnt", o_bit_cnt, BER ? 32'd973 : 32'd0);

        // Clear with simultaneous error, then reset mid-lock
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 100; k++)
            step(1'b1, prbs[k-1] ^ (k == 40 || k == 50 || k == 60), 1'b0, 1'b0);
        check("clr_pre_errcnt", o_err_cnt, BER ? 32'd3 : 32'd0);
        step(1'b1, ~prbs[100], 1'b1, 1'b0);
        check("clr_bitcnt", o_bit_cnt, 0);
        check("clr_errcnt", o_err_cnt, 0);
        check("clr_lock", o_lock, 1);
        check("clr_err", o_err, 1);
        step(1'b1, prbs[101], 1'b0, 1'b0);
        step(1'b1, prbs[102], 1'b0, 1'b1);
        check("midrst_lock", o_lock, 0);
        check("midrst_err", o_err, 0);
        check("midrst_bitcnt", o_bit_cnt, 0);
        check("midrst_errcnt", o_err_cnt, 0);

        // All-zero stream locks
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("zero_lock_at", first_of(lock_at, 0), 27);
        check("zero_errs", err_pulses, 0);

        // Randomized traffic: random phase, enables, errors, bursts, clears, resets
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idx = $urandom_range(0, 510);
        burst = 0;
        for (int c = 0; c < 6000; c++) begin
            en  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 63) == 0);
            r   = ($urandom_range(0, 1499) == 0);
            b   = prbs[idx % 511];
            if (en) begin
                idx++;
                if (burst > 0) begin b = ~b; burst--; end
                else if ($urandom_range(0, 199) == 0) b = ~b;
                else if ($urandom_range(0, 499) == 0) burst = $urandom_range(5, 12);
            end
            step(en, b, clr, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs9_checker.md
PRBS9_CHECKER -- requirements
Module: prbs9_checker

Interface
REQ-001 Parameter: LOCK_CNT, default 18, consecutive correct predictions required to declare lock (range 1..255).
REQ-002 Parameter: WIN, default 64, loss-of-lock observation window in enabled bits (range 2..65535).
REQ-003 Parameter: ERR_THR, default 8, errors within one window that force loss of lock (range 1..WIN).
REQ-004 The clock SHALL be clk, input, 1 bit, rising-edge clock for all state.
REQ-005 The reset SHALL be rst, input, 1 bit, synchronous, active-high.
REQ-006 i_enable, input, 1 bit: i_bit is valid and consumed on this cycle.
REQ-007 i_bit, input, 1 bit: received PRBS9 bit.
REQ-008 i_clr, input, 1 bit: synchronous clear of the statistics counters.
REQ-009 o_lock, output, 1 bit: checker is in the LOCKED state.
REQ-010 o_err, output, 1 bit: one-cycle pulse per mismatched bit while locked.
REQ-011 o_bit_cnt, output, 32 bits: bits compared while locked.
REQ-012 o_err_cnt, output, 32 bits: mismatches counted while locked.

Function
REQ-013 The sequence SHALL be PRBS9, b[n] = b[n-9] XOR b[n-5], x^9+x^5+1, period 511.
REQ-014 The 9-bit history register H SHALL hold the last 9 sequence bits, H[0] oldest; prediction p = H[0] XOR H[4].
REQ-015 All state SHALL advance only on cycles with i_enable=1; i_enable=0 cycles SHALL leave all state unchanged.
REQ-016 The FSM SHALL have two states: SEARCH and LOCKED.
REQ-017 SEARCH: H <= {i_bit, H[8:1]}; a fill counter counts the first 9 enabled bits; no comparison occurs during fill.
REQ-018 SEARCH after fill: i_bit==p increments the match counter; a mismatch clears it to 0.
REQ-019 On the LOCK_CNT-th consecutive match the FSM SHALL enter LOCKED; o_lock rises the next cycle; default is 27 enabled bits after reset.
REQ-020 LOCKED: H <= {p, H[8:1]}, self-running, so received errors SHALL NOT propagate into predictions.
REQ-021 LOCKED: o_err SHALL be registered, high exactly one cycle after each enabled bit with i_bit != p, otherwise low.
REQ-022 LOCKED window: the window counter and window error counter SHALL be 0 on LOCKED entry; the window counter wraps WIN-1 -> 0; both clear at the wrap.
REQ-023 An error on the last bit of a window SHALL count toward that window.
REQ-024 When the window error count reaches ERR_THR, the FSM SHALL go to SEARCH next cycle with fill and match counters cleared and o_lock low.
REQ-025 An all-zero input stream SHALL lock, as the degenerate predicted sequence.
REQ-026 o_bit_cnt SHALL increment per enabled bit in LOCKED; o_err_cnt SHALL increment per mismatch; both saturate at 2^32-1.
REQ-027 i_clr SHALL zero both counters the next cycle with priority over a same-cycle increment; FSM, H and o_lock are unaffected.

Reset
REQ-028 rst SHALL have priority over all inputs.
REQ-029 On rst: FSM=SEARCH, H=0, all counters=0, o_lock=0, o_err=0, o_bit_cnt=0, o_err_cnt=0.
REQ-030 rst asserted mid-lock SHALL drop o_lock the cycle after rst is sampled.

Configuration
REQ-031 Macro PRBS9_CHK_BER_EN defined: o_bit_cnt and o_err_cnt counters SHALL be implemented per REQ-026/027.
REQ-032 Macro PRBS9_CHK_BER_EN undefined: the counters SHALL be omitted; o_bit_cnt and o_err_cnt SHALL be constant 0 and i_clr ignored; ports unchanged, lock and o_err unaffected.

Verification
REQ-033 Stream from a PRBS9 generator seeded 9'h1FF, i_enable=1 continuously, 1000 bits -> o_lock high after bit 27; o_err never high; o_bit_cnt=973; o_err_cnt=0.
REQ-034 Same stream with bit 100 inverted -> exactly one o_err pulse; o_err_cnt=1; o_lock stays high; no further errors.
REQ-035 8 inverted bits at bits 200..207 -> o_lock falls one cycle after the window error count reaches 8; o_lock re-rises 27 clean enabled bits later.
REQ-036 i_enable toggling 1,0,1,0 on the REQ-033 stream -> identical lock point in enabled bits and identical counts; no o_err.
REQ-037 Locked with o_err_cnt=3, pulse i_clr together with an error -> counters read 0 next cycle; o_lock unchanged. rst pulse mid-lock -> all outputs 0.
REQ-038 Build without PRBS9_CHK_BER_EN, REQ-034 stimulus -> o_lock and o_err identical to REQ-034; counters constant 0.
